// File: rtl/top_level_decoder_controller.sv
// Round sequencer for the decoder datapath: runs the inverse round steps
// (addRc, revaluate, permute, rotate, colParity) for ROUNDS rounds, counting down.
module top_level_decoder_controller #(
  parameter int ROUNDS = 24,
  parameter int RW     = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          inv_addRc_ready,
  input  logic          inv_revaluate_ready,
  input  logic          inv_permute_ready,
  input  logic          inv_rotate_ready,
  input  logic          inv_colParity_ready,
  output logic          inv_addRc_go,
  output logic          inv_revaluate_go,
  output logic          inv_permute_go,
  output logic          inv_rotate_go,
  output logic          inv_colParity_go,
  output logic [4:0]    step_sel,
  output logic [RW-1:0] round_idx,
  output logic          load_state,
  output logic          busy,
  output logic          ready,
  output logic          done
);

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    S_ADDRC,
    S_REVAL,
    S_PERM,
    S_ROT,
    S_COLP,
    NEXT,
    FIN
  } state_t;

  localparam logic [RW-1:0] LAST_IDX = RW'(ROUNDS - 1);
  localparam logic [RW-1:0] IDX_ONE  = RW'(1);

  state_t        state;
  state_t        state_nxt;
  logic          first;
  logic          first_nxt;
  logic [RW-1:0] idx_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      first     <= 1'b0;
      round_idx <= '0;
    end else begin
      state     <= state_nxt;
      first     <= first_nxt;
      round_idx <= idx_nxt;
    end
  end

  // A step unit's ready is only trusted once the go cycle (first=1) has passed.
  always_comb begin
    state_nxt = state;
    first_nxt = 1'b0;
    idx_nxt   = round_idx;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = INIT;
          idx_nxt   = LAST_IDX;
        end
      end
      INIT: begin
        idx_nxt = LAST_IDX;
        if (!start) begin
          state_nxt = S_ADDRC;
          first_nxt = 1'b1;
        end
      end
      S_ADDRC: begin
        if (!first && inv_addRc_ready) begin
          state_nxt = S_REVAL;
          first_nxt = 1'b1;
        end
      end
      S_REVAL: begin
        if (!first && inv_revaluate_ready) begin
          state_nxt = S_PERM;
          first_nxt = 1'b1;
        end
      end
      S_PERM: begin
        if (!first && inv_permute_ready) begin
          state_nxt = S_ROT;
          first_nxt = 1'b1;
        end
      end
      S_ROT: begin
        if (!first && inv_rotate_ready) begin
          state_nxt = S_COLP;
          first_nxt = 1'b1;
        end
      end
      S_COLP: begin
        if (!first && inv_colParity_ready) begin
          state_nxt = NEXT;
        end
      end
      NEXT: begin
        if (round_idx != '0) begin
          idx_nxt   = round_idx - IDX_ONE;
          state_nxt = S_ADDRC;
          first_nxt = 1'b1;
        end else begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = round_idx;
      end
    endcase
  end

  always_comb begin
    step_sel   = 5'b00000;
    load_state = 1'b0;
    busy       = 1'b1;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy  = 1'b0;
        ready = 1'b1;
      end
      INIT:    load_state = 1'b1;
      S_ADDRC: step_sel   = 5'b10000;
      S_REVAL: step_sel   = 5'b01000;
      S_PERM:  step_sel   = 5'b00100;
      S_ROT:   step_sel   = 5'b00010;
      S_COLP:  step_sel   = 5'b00001;
      FIN:     done       = 1'b1;
      default: step_sel   = 5'b00000;
    endcase
  end

  // Go pulses only in the entry cycle of each step state.
  assign inv_addRc_go      = step_sel[4] & first;
  assign inv_revaluate_go  = step_sel[3] & first;
  assign inv_permute_go    = step_sel[2] & first;
  assign inv_rotate_go     = step_sel[1] & first;
  assign inv_colParity_go  = step_sel[0] & first;

endmodule

// File: tb/tb_top_level_decoder_controller.sv
// Self-checking bench: a cycle-accurate schedule of expected outputs is built from
// round/step timing rules and compared against two controller instances.
module tb_top_level_decoder_controller;

  typedef struct packed {
    logic        start;
    logic [4:0]  rdy;
    logic [18:0] exp;
  } rec_t;

  logic clk;
  logic rst;
  logic start;
  logic [4:0] rdy;

  logic go24_a, go24_r, go24_p, go24_o, go24_c;
  logic [4:0] sel24, idx24;
  logic load24, busy24, ready24, done24;
  logic go2_a, go2_r, go2_p, go2_o, go2_c;
  logic [4:0] sel2, idx2;
  logic load2, busy2, ready2, done2;

  logic [18:0] out24, out2, act, exp_cur;
  logic exp_valid;
  logic dut_sel;

  rec_t sched[$];
  int abort_mark;
  int checks;
  int fails;
  int cyc;
  int done_cnt;
  int done_cyc;
  int init_cyc;

  top_level_decoder_controller #(.ROUNDS(24), .RW(5)) u_dut24 (
    .clk(clk), .rst(rst), .start(start),
    .inv_addRc_ready(rdy[4]), .inv_revaluate_ready(rdy[3]), .inv_permute_ready(rdy[2]),
    .inv_rotate_ready(rdy[1]), .inv_colParity_ready(rdy[0]),
    .inv_addRc_go(go24_a), .inv_revaluate_go(go24_r), .inv_permute_go(go24_p),
    .inv_rotate_go(go24_o), .inv_colParity_go(go24_c),
    .step_sel(sel24), .round_idx(idx24), .load_state(load24),
    .busy(busy24), .ready(ready24), .done(done24)
  );

  top_level_decoder_controller #(.ROUNDS(2), .RW(5)) u_dut2 (
    .clk(clk), .rst(rst), .start(start),
    .inv_addRc_ready(rdy[4]), .inv_revaluate_ready(rdy[3]), .inv_permute_ready(rdy[2]),
    .inv_rotate_ready(rdy[1]), .inv_colParity_ready(rdy[0]),
    .inv_addRc_go(go2_a), .inv_revaluate_go(go2_r), .inv_permute_go(go2_p),
    .inv_rotate_go(go2_o), .inv_colParity_go(go2_c),
    .step_sel(sel2), .round_idx(idx2), .load_state(load2),
    .busy(busy2), .ready(ready2), .done(done2)
  );

  assign out24 = {ready24, busy24, done24, load24, sel24,
                  {go24_a, go24_r, go24_p, go24_o, go24_c}, idx24};
  assign out2  = {ready2, busy2, done2, load2, sel2,
                  {go2_a, go2_r, go2_p, go2_o, go2_c}, idx2};
  assign act   = dut_sel ? out2 : out24;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] mk(input logic rd, input logic bs, input logic dn,
                                     input logic ld, input logic [4:0] sel,
                                     input logic [4:0] go, input logic [4:0] idx);
    return {rd, bs, dn, ld, sel, go, idx};
  endfunction

  task automatic checkOutput(input string name, input logic [18:0] got, input logic [18:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s at t=%0t: got %b expected %b (rdy,bsy,dn,ld,sel,go,idx)",
               name, $time, got, want);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // One comparison per cycle while a schedule is being played out.
  always @(negedge clk) begin
    cyc++;
    if (exp_valid) begin
      checkOutput("cycle", act, exp_cur);
      if (act[16]) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (act[15] && init_cyc < 0) init_cyc = cyc;
    end
  end

  function automatic logic [4:0] fill(input int mode);
    if (mode == 0) return 5'h1F;
    return 5'($urandom_range(0, 31));
  endfunction

  function automatic logic junkStart(input int mode);
    if (mode == 0) return 1'b0;
    return ($urandom_range(0, 3) == 0);
  endfunction

  // mode 0: all ready tied high; 1: random latency 1..4 with junk;
  // 2: permute latency 7 plus ready in go cycle; 3: latency 1 with junk.
  task automatic buildRun(input int rounds, input int init_len, input int mode,
                          input logic [4:0] prev_idx, input int mark_round);
    rec_t rc;
    logic [4:0] sel;
    int lat;
    sched.delete();
    abort_mark = -1;
    rc.start = 1'b1;
    rc.rdy   = fill(mode);
    rc.exp   = mk(1, 0, 0, 0, 5'd0, 5'd0, prev_idx);
    sched.push_back(rc);
    for (int k = 0; k < init_len; k++) begin
      rc.start = (k < init_len - 1);
      rc.rdy   = fill(mode);
      rc.exp   = mk(0, 1, 0, 1, 5'd0, 5'd0, 5'(rounds - 1));
      sched.push_back(rc);
    end
    for (int r = rounds - 1; r >= 0; r--) begin
      for (int s = 0; s < 5; s++) begin
        sel = 5'b10000 >> s;
        if (mode == 1) lat = int'($urandom_range(1, 4));
        else if (mode == 2 && s == 2) lat = 7;
        else lat = 1;
        rc.start = junkStart(mode);
        rc.rdy   = fill(mode);
        if (mode == 2 && s == 2) rc.rdy = rc.rdy | sel;
        rc.exp   = mk(0, 1, 0, 0, sel, sel, 5'(r));
        sched.push_back(rc);
        for (int j = 1; j <= lat; j++) begin
          rc.start = junkStart(mode);
          rc.rdy   = fill(mode);
          if (mode != 0) rc.rdy = (j == lat) ? (rc.rdy | sel) : (rc.rdy & ~sel);
          rc.exp   = mk(0, 1, 0, 0, sel, 5'd0, 5'(r));
          if (r == mark_round && s == 3 && j == 1) abort_mark = sched.size();
          sched.push_back(rc);
        end
      end
      rc.start = junkStart(mode);
      rc.rdy   = fill(mode);
      rc.exp   = mk(0, 1, 0, 0, 5'd0, 5'd0, 5'(r));
      sched.push_back(rc);
    end
    rc.start = junkStart(mode);
    rc.rdy   = fill(mode);
    rc.exp   = mk(0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
    sched.push_back(rc);
    for (int k = 0; k < 2; k++) begin
      rc.start = 1'b0;
      rc.rdy   = fill(mode);
      rc.exp   = mk(1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      sched.push_back(rc);
    end
  endtask

  task automatic applyStimulus(input int abort_at);
    done_cnt = 0;
    done_cyc = -1;
    init_cyc = -1;
    for (int i = 0; i < sched.size(); i++) begin
      @(posedge clk);
      #1;
      start     = sched[i].start;
      rdy       = sched[i].rdy;
      exp_cur   = sched[i].exp;
      exp_valid = 1'b1;
      if (i == abort_at) begin
        @(negedge clk);
        #1;
        exp_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic applyReset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n_done;
    rst = 1'b0; start = 1'b0; rdy = 5'd0; exp_valid = 1'b0; dut_sel = 1'b0;
    exp_cur = '0; checks = 0; fails = 0; cyc = 0;
    done_cnt = 0; done_cyc = -1; init_cyc = -1; abort_mark = -1;

    #2 rst = 1'b1;
    #1;
    checkOutput("reset24", out24, mk(1, 0, 0, 0, 5'd0, 5'd0, 5'd0));
    checkOutput("reset2", out2, mk(1, 0, 0, 0, 5'd0, 5'd0, 5'd0));
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] full run, ROUNDS=24, ready tied high");
    buildRun(24, 1, 0, 5'd0, -1);
    checkValue("model_len24", sched.size() - 3, 266);
    checkValue("model_first_idx", int'(sched[2].exp[4:0]), 23);
    n_done = 0;
    foreach (sched[i]) if (sched[i].exp[16]) n_done++;
    checkValue("model_done_once", n_done, 1);
    applyStimulus(-1);
    checkValue("done_count24", done_cnt, 1);
    checkValue("run_len24", done_cyc - init_cyc + 1, 266);

    $display("[TB] ROUNDS=2, start held 4 cycles, random latencies");
    dut_sel = 1'b1;
    applyReset();
    buildRun(2, 4, 1, 5'd0, -1);
    applyStimulus(-1);
    checkValue("done_count_hold", done_cnt, 1);

    $display("[TB] ROUNDS=2, slow permute, early ready ignored");
    buildRun(2, 1, 2, 5'd0, -1);
    applyStimulus(-1);

    $display("[TB] ROUNDS=2, start pulses while busy");
    buildRun(2, 1, 3, 5'd0, -1);
    checkValue("model_len2", sched.size() - 3, 24);
    applyStimulus(-1);
    checkValue("done_count2", done_cnt, 1);
    checkValue("run_len2", done_cyc - init_cyc + 1, 24);

    $display("[TB] ROUNDS=24, reset during rotate of round 10");
    dut_sel = 1'b0;
    applyReset();
    buildRun(24, 1, 1, 5'd0, 14);
    applyStimulus(abort_mark);
    rst = 1'b1;
    #1;
    checkOutput("reset_midrun", out24, mk(1, 0, 0, 0, 5'd0, 5'd0, 5'd0));
    @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b0;

    $display("[TB] ROUNDS=24, restart after reset, random latencies");
    buildRun(24, 1, 1, 5'd0, -1);
    applyStimulus(-1);
    checkValue("done_count_restart", done_cnt, 1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/top_level_decoder_controller.md
# top_level_decoder_controller

Sequencing controller for the decoder datapath, the inverse of the encoder's round controller. It runs the inverse round steps in reverse order (inverse addRc, inverse revaluate, inverse permute, inverse rotate, inverse colParity). It runs ROUNDS rounds with an internal round index counting down from ROUNDS-1 to 0. Each step unit gets a one-cycle go pulse and answers with a ready level; the controller reports idle, busy and completion to the top level.

## Interface
- ROUNDS, 24, number of inverse rounds (≥1)
- RW, 5, width of round_idx (2^RW ≥ ROUNDS)

- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin decode request (level)
- inv_addRc_ready  in  1  inverse addRc step finished
- inv_revaluate_ready  in  1  inverse revaluate step finished
- inv_permute_ready  in  1  inverse permute step finished
- inv_rotate_ready  in  1  inverse rotate step finished
- inv_colParity_ready  in  1  inverse colParity step finished
- inv_addRc_go, inv_revaluate_go, inv_permute_go, inv_rotate_go, inv_colParity_go  out  1 each  one-cycle step launch pulse
- step_sel  out  5  one-hot active step, bit4..0 = addRc, revaluate, permute, rotate, colParity; 0 outside step states
- round_idx  out  RW  current round constant index (feeds inverse addRc)
- load_state  out  1  datapath captures input block (INIT)
- busy  out  1  high in every state except IDLE
- ready  out  1  high in IDLE only
- done  out  1  one-cycle pulse on completion

## Operation
- Registers: state, first flag, round_idx. All outputs are Moore-decoded from these registers.
- States: IDLE, INIT, S_ADDRC, S_REVAL, S_PERM, S_ROT, S_COLP, NEXT, FIN.
- IDLE: ready=1. start=1 → INIT.
- INIT: load_state=1, round_idx←ROUNDS-1. Stays in INIT while start=1; start=0 → S_ADDRC.
- Step states, fixed order S_ADDRC→S_REVAL→S_PERM→S_ROT→S_COLP:
  - Entering a step state sets first=1. In that cycle the matching *_go=1.
  - The step's ready is ignored while first=1, and first clears on the next edge.
  - With first=0, ready=1 → next step and first=1. Ready=0 → hold.
  - Only the active step's ready is observed. The others are don't-care.
- S_COLP done → NEXT.
- NEXT: if round_idx≠0, round_idx←round_idx-1 and go to S_ADDRC. If round_idx==0, go to FIN.
- FIN: done=1 for exactly one cycle, then IDLE.
- start while busy is ignored.
- A new start in IDLE right after FIN begins a fresh run.
- round_idx holds its last value (0) in IDLE after completion.
- Reset, at power-up or mid-operation, takes effect immediately:
  - state=IDLE, first=0, round_idx=0.
  - Outputs: ready=1, busy=0, done=0, all *_go=0, step_sel=0, load_state=0, round_idx=0.
- Illegal state encodings → IDLE on the next edge.

## Timing
- start sampled at edge k → INIT from k+1. The first step state begins the cycle after start is first seen low in INIT.
- Each step takes at least 2 cycles: go cycle, then ready cycle. It takes 1+N cycles when ready first rises N cycles after go (N≥1).
- Ready asserted in the go cycle is not accepted. The step unit must still present ready at or after the following cycle.
- Round with immediate responders: 5×2 + 1 (NEXT) = 11 cycles.
- Full run: 1 INIT cycle (start released) + 11×ROUNDS + 1 FIN. For ROUNDS=24 that is 266 cycles, and ready returns to 1 on cycle 267.
- round_idx changes only at INIT entry, NEXT exit and reset. It is stable for the whole round.

## Test plan
- Reset values: assert rst mid-clock → ready=1, busy=0, done=0, round_idx=0, step_sel=0, all go=0 without waiting for a clock edge.
- Full run, ROUNDS=24, every ready tied high:
  - go pulses appear in order addRc, revaluate, permute, rotate, colParity, each 2 cycles apart.
  - round_idx reads 23 down to 0.
  - done pulses once, 266 cycles after INIT entry; ready=1 next cycle.
- start held high 4 cycles → INIT and load_state held 4 cycles, no go pulse until start=0.
- Step responders with varying latency (inv_permute_ready 7 cycles after go, others 1) → controller holds in S_PERM with step_sel=00100 until ready, with no duplicate go pulse. A ready pulse in the go cycle is ignored.
- rst asserted in round 10 during S_ROT → immediate IDLE, round_idx=0. A new start then restarts at round_idx=23.
- ROUNDS=2: start pulse while busy ignored → exactly 2 rounds (idx 1, 0), done once, 24 cycles total.
